// File: rtl/store_merge_if.sv
`default_nettype none
// ============================================================================
//  Module      : store_merge_if
//  Description : Request and memory-side bus bundle for store_merge_unit.
//                slave  modport - seen by the store engine
//                master modport - seen by the requester / memory model
//  Signals     : req_valid/req_ready/req_addr/req_data/req_size  store request
//                mem_addr/mem_rd/mem_wr/mem_wdata/mem_rdata        data memory
//                busy/done/misalign                                status
//  Revision    : 1.0  initial release
// ============================================================================
interface store_merge_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              done;
    logic              misalign;

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_rdata,
        output req_ready, mem_addr, mem_rd, mem_wr, mem_wdata, busy, done, misalign
    );

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_rdata,
        input  req_ready, mem_addr, mem_rd, mem_wr, mem_wdata, busy, done, misalign
    );
endinterface
`default_nettype wire

// File: rtl/store_merge_unit.sv
`default_nettype none
// ============================================================================
//  Module      : store_merge_unit
//  Description : Sub-word store engine. Byte/half/word stores narrower than
//                the memory word run read-modify-write (read aligned word,
//                merge new bytes into their little-endian lanes, write back);
//                full-width stores are written directly.
//  Parameters  : DATA_W (memory word bits, pow2 >= 32), ADDR_W (byte address
//                bits), RD_LAT (memory read latency, >= 1)
//  Ports       : clk, reset (sync, active-high), bus (store_merge_if.slave)
//  Options     : STORE_MISALIGN_EXC_EN - when defined, misaligned requests are
//                rejected with a done+misalign pulse and no memory access;
//                otherwise the address is aligned down to the access size.
//  Revision    : 1.0  initial release
// ============================================================================
module store_merge_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  wire logic         clk,
    input  wire logic         reset,
    store_merge_if.slave      bus
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF   = $clog2(NB);
    localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_FULL = 2'b11;
    localparam bit WORD_IS_FULL = (DATA_W == 32);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_WAIT  = 3'd2,
        S_MERGE = 3'd3,
        S_WR    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;   // also the latched aligned address
    logic [OFF-1:0]    lane_q, lane_d;
    logic [1:0]        size_q, size_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              busy_q, busy_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    // ------------------------------------------------------------------
    // Request decode (only meaningful while idle)
    // ------------------------------------------------------------------
    logic           w_req_full;
    logic [OFF-1:0] w_req_lane;
    logic [OFF-1:0] w_lane_aligned;

    always_comb begin
        w_req_lane     = bus.req_addr[OFF-1:0];
        w_req_full     = (bus.req_size == SZ_FULL) ||
                         ((bus.req_size == SZ_WORD) && WORD_IS_FULL);
        w_lane_aligned = w_req_lane;
        if (w_req_full) begin
            w_lane_aligned = '0;
        end else if (bus.req_size == SZ_HALF) begin
            w_lane_aligned[0] = 1'b0;
        end else if (bus.req_size == SZ_WORD) begin
            w_lane_aligned[1:0] = 2'b00;
        end
    end

`ifdef STORE_MISALIGN_EXC_EN
    logic w_req_misalign;
    logic misalign_q, misalign_d;

    always_comb begin
        w_req_misalign = 1'b0;
        if (w_req_full) begin
            w_req_misalign = |w_req_lane;
        end else if (bus.req_size == SZ_HALF) begin
            w_req_misalign = w_req_lane[0];
        end else if (bus.req_size == SZ_WORD) begin
            w_req_misalign = |w_req_lane[1:0];
        end
    end
`endif

    // ------------------------------------------------------------------
    // Lane merge: old word with bytes lane..lane+n-1 replaced
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_ones;
    logic [DATA_W-1:0] w_low_mask;
    logic [DATA_W-1:0] w_merged;
    logic [OFF+2:0]    w_sh;

    always_comb begin
        w_ones = '1;
        case (size_q)
            SZ_BYTE: w_low_mask = w_ones >> (DATA_W - 8);
            SZ_HALF: w_low_mask = w_ones >> (DATA_W - 16);
            default: w_low_mask = w_ones >> (DATA_W - 32);
        endcase
        w_sh     = {lane_q, 3'b000};
        w_merged = (bus.mem_rdata & ~(w_low_mask << w_sh)) |
                   ((data_q & w_low_mask) << w_sh);
    end

    // ------------------------------------------------------------------
    // Next state and next (registered) outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        lane_d      = lane_q;
        size_d      = size_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        mem_wdata_d = '0;
`ifdef STORE_MISALIGN_EXC_EN
        misalign_d  = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    mem_addr_d = {bus.req_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
                    lane_d     = w_lane_aligned;
                    size_d     = bus.req_size;
                    data_d     = bus.req_data;
`ifdef STORE_MISALIGN_EXC_EN
                    if (w_req_misalign) begin
                        state_d    = S_DONE;
                        misalign_d = 1'b1;
                    end else
`endif
                    if (w_req_full) begin
                        state_d     = S_WR;
                        mem_wdata_d = bus.req_data;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                state_d = (RD_LAT > 1) ? S_WAIT : S_MERGE;
                cnt_d   = CNT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_MERGE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_MERGE: begin
                state_d     = S_WR;
                mem_wdata_d = w_merged;
            end
            S_WR:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        mem_rd_d    = (state_d == S_RD);
        mem_wr_d    = (state_d == S_WR);
        done_d      = (state_d == S_DONE);
        if (state_d == S_IDLE) begin
            mem_addr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mem_addr_q  <= '0;
            lane_q      <= '0;
            size_q      <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;   // ready as soon as reset drops
            busy_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            done_q      <= 1'b0;
            mem_wdata_q <= '0;
`ifdef STORE_MISALIGN_EXC_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            lane_q      <= lane_d;
            size_q      <= size_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            done_q      <= done_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef STORE_MISALIGN_EXC_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    // Outputs are forced low for the whole reset cycle, so an in-flight
    // write or done pulse is suppressed in the very cycle reset rises.
    assign bus.req_ready = req_ready_q & ~reset;
    assign bus.busy      = busy_q & ~reset;
    assign bus.mem_rd    = mem_rd_q & ~reset;
    assign bus.mem_wr    = mem_wr_q & ~reset;
    assign bus.done      = done_q & ~reset;
    assign bus.mem_addr  = reset ? '0 : mem_addr_q;
    assign bus.mem_wdata = reset ? '0 : mem_wdata_q;
`ifdef STORE_MISALIGN_EXC_EN
    assign bus.misalign  = misalign_q & ~reset;
`else
    assign bus.misalign  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_merge_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_merge_unit
//  Description : Directed self-checking bench for store_merge_unit.
//                dut0: DATA_W=32, RD_LAT=1   dut1: DATA_W=64, RD_LAT=3
//  Revision    : 1.0  initial release
// ============================================================================
module tb_store_merge_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    store_merge_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();
    store_merge_if #(.DATA_W(64), .ADDR_W(32)) bus1 ();

    store_merge_unit #(.DATA_W(32), .ADDR_W(32), .RD_LAT(1)) u_dut0 (
        .clk(clk), .reset(rst0), .bus(bus0.slave));
    store_merge_unit #(.DATA_W(64), .ADDR_W(32), .RD_LAT(3)) u_dut1 (
        .clk(clk), .reset(rst1), .bus(bus1.slave));

    // memory models (read-only contents; writes are only observed)
    logic [31:0] mem0 [0:255];
    logic [63:0] mem1 [0:15];
    logic [31:0] rp0 = '0;
    logic [63:0] rp1 [0:2];
    always @(posedge clk) begin
        rp0    <= bus0.mem_rd ? mem0[bus0.mem_addr[9:2]] : 32'd0;
        rp1[0] <= bus1.mem_rd ? mem1[bus1.mem_addr[6:3]] : 64'd0;
        rp1[1] <= rp1[0];
        rp1[2] <= rp1[1];
    end
    assign bus0.mem_rdata = rp0;
    assign bus1.mem_rdata = rp1[2];

    // monitors
    int rd_n0 = 0, wr_n0 = 0, dn_n0 = 0, ovl0 = 0, bad0 = 0;
    int rd_n1 = 0, wr_n1 = 0, dn_n1 = 0, ovl1 = 0, bad1 = 0;
    logic [31:0] rd_c0 = '0, wr_c0 = '0, dn_c0 = '0, rd_a0 = '0, wr_a0 = '0, wr_d0 = '0;
    logic [31:0] rd_c1 = '0, wr_c1 = '0, dn_c1 = '0, rd_a1 = '0, wr_a1 = '0;
    logic [63:0] wr_d1 = '0;
    logic        mis0 = 1'b0;

    always @(negedge clk) begin
        if (bus0.mem_rd) begin rd_n0 <= rd_n0 + 1; rd_c0 <= cyc; rd_a0 <= bus0.mem_addr; end
        if (bus0.mem_wr) begin wr_n0 <= wr_n0 + 1; wr_c0 <= cyc; wr_a0 <= bus0.mem_addr; wr_d0 <= bus0.mem_wdata; end
        if (bus0.done)   begin dn_n0 <= dn_n0 + 1; dn_c0 <= cyc; mis0 <= bus0.misalign; end
        if (bus0.mem_rd && bus0.mem_wr) ovl0 <= ovl0 + 1;
        if ((!bus0.mem_wr && bus0.mem_wdata != 0) || (bus0.req_ready && bus0.busy)) bad0 <= bad0 + 1;
        if (bus1.mem_rd) begin rd_n1 <= rd_n1 + 1; rd_c1 <= cyc; rd_a1 <= bus1.mem_addr; end
        if (bus1.mem_wr) begin wr_n1 <= wr_n1 + 1; wr_c1 <= cyc; wr_a1 <= bus1.mem_addr; wr_d1 <= bus1.mem_wdata; end
        if (bus1.done)   begin dn_n1 <= dn_n1 + 1; dn_c1 <= cyc; end
        if (bus1.mem_rd && bus1.mem_wr) ovl1 <= ovl1 + 1;
        if ((!bus1.mem_wr && bus1.mem_wdata != 0) || (bus1.req_ready && bus1.busy)) bad1 <= bad1 + 1;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one request, wait for acceptance and for the done pulse.
    task automatic do_store(input int which, input logic [31:0] a, input logic [63:0] d,
                            input logic [1:0] s, output logic [31:0] acc);
        bit ok;
        bit seen;
        @(posedge clk); #1;
        if (which == 0) begin
            bus0.req_valid = 1'b1; bus0.req_addr = a; bus0.req_data = d[31:0]; bus0.req_size = s;
        end else begin
            bus1.req_valid = 1'b1; bus1.req_addr = a; bus1.req_data = d; bus1.req_size = s;
        end
        ok  = 1'b0;
        acc = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((which == 0) ? bus0.req_ready : bus1.req_ready) begin
                acc = cyc; ok = 1'b1; break;
            end
        end
        check_eq("accept_timeout", {63'd0, ok}, 64'd1);
        @(posedge clk); #1;
        bus0.req_valid = 1'b0; bus0.req_data = '1;
        bus1.req_valid = 1'b0; bus1.req_data = '1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((which == 0) ? bus0.done : bus1.done) begin seen = 1'b1; break; end
        end
        check_eq("done_timeout", {63'd0, seen}, 64'd1);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] acc, acc2;
        int r0, w0, d0;
        bit ok;
        for (int i = 0; i < 256; i++) mem0[i] = '0;
        for (int i = 0; i < 16; i++)  mem1[i] = '0;
        bus0.req_valid = 0; bus0.req_addr = 0; bus0.req_data = 0; bus0.req_size = 0;
        bus1.req_valid = 0; bus1.req_addr = 0; bus1.req_data = 0; bus1.req_size = 0;

        // reset state
        repeat (3) @(negedge clk);
        check_eq("rst_ready", {63'd0, bus0.req_ready}, 64'd0);
        check_eq("rst_busy",  {63'd0, bus0.busy}, 64'd0);
        check_eq("rst_addr",  {32'd0, bus0.mem_addr}, 64'd0);
        check_eq("rst_ready1", {63'd0, bus1.req_ready}, 64'd0);
        @(posedge clk); #1; rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", {63'd0, bus0.req_ready}, 64'd1);
        check_eq("post_rst_ready1", {63'd0, bus1.req_ready}, 64'd1);

        // byte store 0x103 <- AB, old 11223344
        mem0[64] = 32'h11223344;
        r0 = rd_n0;
        do_store(0, 32'h103, 64'hAB, 2'b00, acc);
        check_eq("b_rd_cnt",  rd_n0 - r0, 1);
        check_eq("b_rd_cyc",  rd_c0, acc + 1);
        check_eq("b_rd_addr", rd_a0, 32'h100);
        check_eq("b_wr_cyc",  wr_c0, acc + 3);
        check_eq("b_wr_addr", wr_a0, 32'h100);
        check_eq("b_wr_data", wr_d0, 32'hAB223344);
        check_eq("b_done_cyc", dn_c0, acc + 4);

        // halfword store 0x102 <- BEEF
        do_store(0, 32'h102, 64'hBEEF, 2'b01, acc);
        check_eq("h_wr_addr", wr_a0, 32'h100);
        check_eq("h_wr_data", wr_d0, 32'hBEEF3344);

        // word store (full width on 32-bit bus)
        r0 = rd_n0;
        do_store(0, 32'h200, 64'hDEADBEEF, 2'b10, acc);
        check_eq("w_no_rd",   rd_n0 - r0, 0);
        check_eq("w_wr_cyc",  wr_c0, acc + 1);
        check_eq("w_wr_data", wr_d0, 32'hDEADBEEF);
        check_eq("w_wr_addr", wr_a0, 32'h200);
        check_eq("w_done_cyc", dn_c0, acc + 2);

        // size 11 on 32-bit bus: identical to word
        do_store(0, 32'h204, 64'h01020304, 2'b11, acc);
        check_eq("f_wr_cyc",  wr_c0, acc + 1);
        check_eq("f_wr_data", wr_d0, 32'h01020304);

        // misaligned halfword 0x101
        r0 = rd_n0; w0 = wr_n0;
        do_store(0, 32'h101, 64'hCAFE, 2'b01, acc);
`ifdef STORE_MISALIGN_EXC_EN
        check_eq("m_no_rd",   rd_n0 - r0, 0);
        check_eq("m_no_wr",   wr_n0 - w0, 0);
        check_eq("m_done_cyc", dn_c0, acc + 1);
        check_eq("m_misalign", {63'd0, mis0}, 64'd1);
`else
        check_eq("m_wr_cnt",  wr_n0 - w0, 1);
        check_eq("m_wr_addr", wr_a0, 32'h100);
        check_eq("m_wr_data", wr_d0, 32'h1122CAFE);
        check_eq("m_misalign", {63'd0, mis0}, 64'd0);
`endif

        // two queued stores with valid held high
        w0 = wr_n0;
        @(posedge clk); #1;
        bus0.req_valid = 1'b1; bus0.req_addr = 32'h300; bus0.req_data = 32'hA5A5A5A5; bus0.req_size = 2'b10;
        ok = 1'b0; acc = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus0.req_ready) begin acc = cyc; ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        bus0.req_addr = 32'h304; bus0.req_data = 32'h5A5A5A5A;
        acc2 = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus0.req_ready) begin acc2 = cyc; ok = ok & 1'b1; break; end
            if (i == 19) ok = 1'b0;
        end
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check_eq("q_accepted", {63'd0, ok}, 64'd1);
        check_eq("q_gap",      acc2 - acc, 32'd3);
        check_eq("q_wr_cnt",   wr_n0 - w0, 2);
        check_eq("q_wr_addr",  wr_a0, 32'h304);
        check_eq("q_wr_data",  wr_d0, 32'h5A5A5A5A);
        check_eq("q_overlap",  ovl0, 0);

        // dut1: reset during the second WAIT cycle
        w0 = wr_n1; d0 = dn_n1;
        @(posedge clk); #1;
        bus1.req_valid = 1'b1; bus1.req_addr = 32'h10; bus1.req_data = 64'h77; bus1.req_size = 2'b00;
        ok = 1'b0; acc = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus1.req_ready) begin acc = cyc; ok = 1'b1; break; end
        end
        check_eq("r_accepted", {63'd0, ok}, 64'd1);
        @(posedge clk); #1; bus1.req_valid = 1'b0;   // RD
        @(posedge clk); #1;                           // WAIT 1
        @(negedge clk);
        check_eq("r_busy_wait", {63'd0, bus1.busy}, 64'd1);
        @(posedge clk); #1; rst1 = 1'b1;              // WAIT 2
        @(negedge clk);
        check_eq("r_rd_cyc",   rd_c1, acc + 1);
        check_eq("r_busy_rst", {63'd0, bus1.busy}, 64'd0);
        check_eq("r_wr_rst",   {63'd0, bus1.mem_wr}, 64'd0);
        @(posedge clk); #1; rst1 = 1'b0;
        @(negedge clk);
        check_eq("r_ready_after", {63'd0, bus1.req_ready}, 64'd1);
        repeat (8) @(negedge clk);
        #1;
        check_eq("r_no_wr",   wr_n1 - w0, 0);
        check_eq("r_no_done", dn_n1 - d0, 0);

        // dut1: byte store 0x7 <- 5A, old 0
        mem1[0] = 64'h0;
        do_store(1, 32'h7, 64'h5A, 2'b00, acc);
        check_eq("d_rd_cyc",  rd_c1, acc + 1);
        check_eq("d_rd_addr", rd_a1, 32'h0);
        check_eq("d_wr_cyc",  wr_c1, acc + 5);
        check_eq("d_wr_addr", wr_a1, 32'h0);
        check_eq("d_wr_data", wr_d1, 64'h5A00000000000000);
        check_eq("d_done_cyc", dn_c1, acc + 6);

        // dut1: word store (sub-word on 64-bit bus) 0x4
        mem1[0] = 64'h1111111122222222;
        do_store(1, 32'h4, 64'hDEADBEEF, 2'b10, acc);
        check_eq("dw_wr_data", wr_d1, 64'hDEADBEEF22222222);

        // dut1: full-width store 0x8
        r0 = rd_n1;
        do_store(1, 32'h8, 64'h0123456789ABCDEF, 2'b11, acc);
        check_eq("df_no_rd",   rd_n1 - r0, 0);
        check_eq("df_wr_cyc",  wr_c1, acc + 1);
        check_eq("df_wr_addr", wr_a1, 32'h8);
        check_eq("df_wr_data", wr_d1, 64'h0123456789ABCDEF);

        check_eq("bad0", bad0, 0);
        check_eq("bad1", bad1, 0);
        check_eq("ovl1", ovl1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
